// File: rtl/fifo_reader_pkg.sv
// fifo_reader_pkg: shared state encoding and default widths for the FIFO reader.
package fifo_reader_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_CNT_WIDTH  = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } state_e;

endpackage

// File: rtl/fifo_reader_skid.sv
// fifo_reader_skid: 2-entry in-order buffer between the FIFO read port and the
// output stream. Entry 0 is always the oldest word and drives data_o directly,
// so the output holds stable while it waits for the consumer.
module fifo_reader_skid
  import fifo_reader_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] din_i,
  input  logic                  pop_i,
  output logic                  valid_o,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic [1:0]            count_o
);

  logic [DATA_WIDTH-1:0] ent0_q, ent1_q;
  logic [1:0]            cnt_q;

  // Shift/fill the two entries; push+pop together keeps occupancy unchanged.
  // The issue logic upstream never pushes into a full buffer without a pop.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ent0_q <= '0;
      ent1_q <= '0;
      cnt_q  <= 2'd0;
    end else begin
      case ({push_i, pop_i})
        2'b10: begin
          if (cnt_q == 2'd0) ent0_q <= din_i;
          else               ent1_q <= din_i;
          cnt_q <= cnt_q + 2'd1;
        end
        2'b01: begin
          ent0_q <= ent1_q;
          cnt_q  <= cnt_q - 2'd1;
        end
        2'b11: begin
          if (cnt_q == 2'd1) begin
            ent0_q <= din_i;
          end else begin
            ent0_q <= ent1_q;
            ent1_q <= din_i;
          end
        end
        default: ;
      endcase
    end
  end

  assign valid_o = (cnt_q != 2'd0);
  assign data_o  = ent0_q;
  assign count_o = cnt_q;

endmodule

// File: rtl/fifo_reader.sv
// fifo_reader: drains a FIFO read port (1-cycle read latency) into a
// valid/ready stream through a 2-entry skid buffer, under an IDLE/RUN/STOP FSM.
// Optional feature macro: FIFO_READER_CHECKSUM_EN adds a running-XOR checksum
// output over all transferred words.
module fifo_reader
  import fifo_reader_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
  input  logic                  CLK_RD,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  empty,
  input  logic                  rd_rdy,
  input  logic [DATA_WIDTH-1:0] dout,
  output logic                  rd_en,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  input  logic                  m_ready,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  word_count
`ifdef FIFO_READER_CHECKSUM_EN
  ,
  output logic [DATA_WIDTH-1:0] checksum
`endif
);

  logic [1:0]           rst_sync_q;
  logic                 rst_n;
  state_e               state_q;
  logic                 rd_inflight_q;
  logic [CNT_WIDTH-1:0] word_count_q;
  logic [1:0]           buf_cnt;
  logic                 xfer;
  logic [2:0]           pending;

  // Reset asserts asynchronously, releases two edges later.
  always_ff @(posedge CLK_RD or negedge reset) begin
    if (!reset) rst_sync_q <= 2'b00;
    else        rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  assign rst_n = rst_sync_q[1];

  assign xfer = m_valid && m_ready;

  // Occupancy seen by the issue logic counts the word leaving this cycle as
  // already gone; otherwise the read pipe bubbles and cannot sustain 1/cycle.
  assign pending = 3'(buf_cnt) + 3'(rd_inflight_q) - 3'(xfer);
  assign rd_en   = (state_q == RUN) && !empty && (pending < 3'd2);

  // Control FSM; STOP only retires once nothing is in flight or buffered.
  always_ff @(posedge CLK_RD or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      case (state_q)
        IDLE: if (enable) state_q <= RUN;
        RUN:  if (!enable) state_q <= STOP;
        STOP: begin
          if (enable)                                      state_q <= RUN;
          else if (!rd_inflight_q && (buf_cnt == 2'd0))    state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // An accepted read returns data on the next edge.
  always_ff @(posedge CLK_RD or negedge rst_n) begin
    if (!rst_n) rd_inflight_q <= 1'b0;
    else        rd_inflight_q <= rd_en && rd_rdy;
  end

  // Delivered-word counter, wraps naturally.
  always_ff @(posedge CLK_RD or negedge rst_n) begin
    if (!rst_n)    word_count_q <= '0;
    else if (xfer) word_count_q <= word_count_q + 1'b1;
  end

  fifo_reader_skid #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid (
    .clk_i   (CLK_RD),
    .rst_ni  (rst_n),
    .push_i  (rd_inflight_q),
    .din_i   (dout),
    .pop_i   (xfer),
    .valid_o (m_valid),
    .data_o  (m_data),
    .count_o (buf_cnt)
  );

  assign busy       = (state_q != IDLE);
  assign word_count = word_count_q;

`ifdef FIFO_READER_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] cks_q;

  // Running XOR of every word handed downstream.
  always_ff @(posedge CLK_RD or negedge rst_n) begin
    if (!rst_n)    cks_q <= '0;
    else if (xfer) cks_q <= cks_q ^ m_data;
  end

  assign checksum = cks_q;
`endif

endmodule

// File: tb/tb_fifo_reader.sv
// tb_fifo_reader: directed + randomized bench for fifo_reader with a
// queue-based reference model (source FIFO, outstanding words, counters).
module tb_fifo_reader;

  localparam int DW = 32;
  localparam int CW = 4;

  logic          CLK_RD  = 1'b0;
  logic          reset   = 1'b1;
  logic          enable  = 1'b0;
  logic          empty   = 1'b1;
  logic          rd_rdy  = 1'b1;
  logic          m_ready = 1'b0;
  logic [DW-1:0] dout    = '0;
  logic          rd_en, m_valid, busy;
  logic [DW-1:0] m_data;
  logic [CW-1:0] word_count;
`ifdef FIFO_READER_CHECKSUM_EN
  logic [DW-1:0] checksum;
`endif

  fifo_reader #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .CLK_RD     (CLK_RD),
    .reset      (reset),
    .enable     (enable),
    .empty      (empty),
    .rd_rdy     (rd_rdy),
    .dout       (dout),
    .rd_en      (rd_en),
    .m_valid    (m_valid),
    .m_data     (m_data),
    .m_ready    (m_ready),
    .busy       (busy),
    .word_count (word_count)
`ifdef FIFO_READER_CHECKSUM_EN
    ,
    .checksum   (checksum)
`endif
  );

  always #5 CLK_RD = ~CLK_RD;

  int            n_tests = 0, n_fail = 0;
  logic [DW-1:0] src_q[$];   // words waiting in the external FIFO
  logic [DW-1:0] exp_q[$];   // words read but not yet delivered, in order
  bit            infl;       // read accepted at last edge, data on dout now
  int            buffered;   // words captured but not delivered
  logic [CW-1:0] cnt_m;
  logic [DW-1:0] cks_m;
  int            delivered, n_acc, stop_after;
  int            rdy_mode;   // 0 high, 1 toggle, 2 random, 3 low
  bit            rdy_tgl, rand_rd, rand_empty;
  bit            prev_stall;
  logic [DW-1:0] prev_data;
  int            cyc_no, first_rd, first_mv, first_xfer, last_xfer;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive at negedge, check, then model the read pipe at posedge.
  task automatic cyc();
    bit            acc;
    logic [DW-1:0] w;
    @(negedge CLK_RD);
    cyc_no++;
    case (rdy_mode)
      0: m_ready = 1'b1;
      1: begin rdy_tgl = !rdy_tgl; m_ready = rdy_tgl; end
      2: m_ready = 1'($urandom_range(0, 1));
      default: m_ready = 1'b0;
    endcase
    rd_rdy = rand_rd ? ($urandom_range(0, 3) != 0) : 1'b1;
    empty  = (rand_empty && ($urandom_range(0, 3) == 0)) || (src_q.size() == 0);
    #1;
    chk("m_valid", m_valid, buffered > 0);
    if (prev_stall) chk("m_data_hold", m_data, prev_data);
    if (m_valid && m_ready) begin
      chk("xfer_has_word", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        w = exp_q.pop_front();
        chk("m_data", m_data, w);
      end
      cnt_m++;
      cks_m = cks_m ^ m_data;
      buffered--;
      delivered++;
      if (first_xfer < 0) first_xfer = cyc_no;
      last_xfer = cyc_no;
    end
    if (empty) chk("rd_en_when_empty", rd_en, 0);
    if (rd_en && first_rd < 0) first_rd = cyc_no;
    if (m_valid && first_mv < 0) first_mv = cyc_no;
    acc = rd_en && rd_rdy;
    if (acc && stop_after > 0 && n_acc + 1 == stop_after) enable = 1'b0;
    prev_stall = m_valid && !m_ready;
    prev_data  = m_data;
    @(posedge CLK_RD);
    if (infl) buffered++;
    infl = acc;
    if (acc) begin
      n_acc++;
      if (src_q.size() > 0) w = src_q.pop_front();
      else                  w = 'x;
      exp_q.push_back(w);
    end
    #1;
    dout = acc ? w : $urandom;
    chk("buffered_le2", buffered <= 2, 1);
    chk("word_count", word_count, cnt_m);
`ifdef FIFO_READER_CHECKSUM_EN
    chk("checksum", checksum, cks_m);
`endif
  endtask

  task automatic run_until(input int target, input int budget, input string tag);
    int k = 0;
    while (delivered < target && k < budget) begin cyc(); k++; end
    chk({tag, "_done"}, delivered, target);
  endtask

  task automatic drain(input int budget, input string tag);
    int k = 0;
    enable = 1'b0;
    while (busy !== 1'b0 && k < budget) begin cyc(); k++; end
    chk({tag, "_idle"}, busy, 0);
  endtask

  task automatic apply_reset(input string tag);
    @(negedge CLK_RD);
    #2 reset = 1'b0;
    #1;
    chk({tag, "_m_valid"}, m_valid, 0);
    chk({tag, "_rd_en"}, rd_en, 0);
    chk({tag, "_word_count"}, word_count, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_m_data"}, m_data, 0);
    exp_q.delete();
    infl = 0; buffered = 0; cnt_m = '0; cks_m = '0; prev_stall = 0;
    repeat (2) @(posedge CLK_RD);
    @(negedge CLK_RD);
    reset = 1'b1;
    @(posedge CLK_RD);
    #1 chk({tag, "_rd_en_sync"}, rd_en, 0);
  endtask

  task automatic load(input int first, input int n);
    for (int i = 0; i < n; i++) src_q.push_back(DW'(first + i));
  endtask

  initial begin
    rdy_mode = 0; rand_rd = 0; rand_empty = 0; stop_after = 0;
    cyc_no = 0; n_acc = 0; delivered = 0;
    enable = 1'b1;
    apply_reset("rst0");

    // Streaming at full rate, 0..9.
    first_rd = -1; first_mv = -1; first_xfer = -1; last_xfer = -1;
    load(0, 10);
    run_until(10, 40, "stream");
    chk("stream_latency", first_mv - first_rd, 2);
    chk("stream_back2back", last_xfer - first_xfer, 9);
    chk("stream_count", word_count, 10);
    drain(20, "stream");

    // Consumer toggling every cycle; counter wraps 20 -> 4.
    delivered = 0; rdy_mode = 1; enable = 1'b1;
    load(0, 10);
    run_until(10, 60, "toggle");
    chk("toggle_wrap", word_count, 4);
    drain(20, "toggle");

    // Enable dropped as the third read issues.
    delivered = 0; n_acc = 0; stop_after = 3; rdy_mode = 0; enable = 1'b1;
    load(100, 10);
    drain(0, "stop_pre");
    enable = 1'b1;
    stop_after = 3;
    for (int i = 0; i < 30 && busy !== 1'b0 || i < 3; i++) cyc();
    chk("stop_reads", n_acc, 3);
    chk("stop_delivered", delivered, 3);
    chk("stop_idle", busy, 0);
    stop_after = 0;
    src_q.delete();

    // FIFO runs dry after word 4, then refills.
    delivered = 0; enable = 1'b1;
    load(0, 5);
    run_until(5, 30, "dry");
    repeat (3) cyc();
    chk("dry_m_valid", m_valid, 0);
    chk("dry_rd_en", rd_en, 0);
    chk("dry_busy", busy, 1);
    load(5, 5);
    run_until(10, 30, "refill");
    drain(20, "refill");

    // Randomized stream.
    delivered = 0; rdy_mode = 2; rand_rd = 1; rand_empty = 1; enable = 1'b1;
    for (int i = 0; i < 40; i++) src_q.push_back($urandom);
    run_until(40, 600, "rand");
    rand_empty = 0;
    drain(40, "rand");
    rand_rd = 0;

    // Reset while output is valid and stalled.
    rdy_mode = 3; enable = 1'b1;
    load(50, 10);
    for (int i = 0; i < 10 && m_valid !== 1'b1; i++) cyc();
    chk("midrst_pre_valid", m_valid, 1);
    apply_reset("midrst");
    src_q.delete();
    delivered = 0; rdy_mode = 0; enable = 1'b1;
    load(0, 10);
    run_until(10, 40, "after_rst");
    chk("after_rst_count", word_count, 10);
    drain(20, "after_rst");

`ifdef FIFO_READER_CHECKSUM_EN
    apply_reset("cks");
    delivered = 0; enable = 1'b1;
    src_q.push_back(32'h1); src_q.push_back(32'h2); src_q.push_back(32'h4);
    run_until(3, 20, "cks");
    chk("cks_value", checksum, 32'h7);
    drain(20, "cks");
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_reader.md
FIFO_READER -- requirements
Module: fifo_reader

Interface
REQ-001 Parameter DATA_WIDTH, default 32, SHALL set FIFO word and output stream width.
REQ-002 Parameter CNT_WIDTH, default 16, SHALL set delivered-word counter width.
REQ-003 Port CLK_RD  input  1  SHALL be the single clock; all state on its rising edge.
REQ-004 Port reset  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 Port enable  input  1  SHALL request draining of the FIFO read port.
REQ-006 Port empty  input  1  SHALL be the FIFO empty flag.
REQ-007 Port rd_rdy  input  1  SHALL be the FIFO read-ready flag.
REQ-008 Port dout  input  DATA_WIDTH  SHALL be FIFO read data, valid one cycle after an accepted read.
REQ-009 Port rd_en  output  1  SHALL request one FIFO read per cycle.
REQ-010 Port m_valid  output  1  SHALL flag valid output data.
REQ-011 Port m_data  output  DATA_WIDTH  SHALL carry output data.
REQ-012 Port m_ready  input  1  SHALL be downstream acceptance.
REQ-013 Port busy  output  1  SHALL be high in any state other than IDLE.
REQ-014 Port word_count  output  CNT_WIDTH  SHALL count words delivered downstream.

Function
REQ-015 A FIFO read SHALL be accepted when rd_en && rd_rdy at a rising edge; dout SHALL be captured on the following rising edge.
REQ-016 rd_en SHALL be asserted only when state==RUN, empty==0, and (buffered words + in-flight reads) < 2.
REQ-017 Captured words SHALL enter a 2-entry skid buffer; no word SHALL be dropped or duplicated, including when m_ready falls while a read is in flight.
REQ-018 m_valid SHALL be high whenever the buffer is non-empty; m_data SHALL be the oldest buffered word and SHALL hold stable while m_valid && !m_ready.
REQ-019 A transfer SHALL occur on m_valid && m_ready; capture and transfer in the same cycle SHALL leave occupancy unchanged.
REQ-020 With m_ready held high and FIFO non-empty, sustained throughput SHALL be one word per cycle; latency rd_en to m_valid SHALL be 2 cycles.
REQ-021 FSM states SHALL be IDLE, RUN, STOP; IDLE->RUN on enable=1; RUN->STOP on enable=0; STOP->IDLE when no read in flight and buffer empty; STOP->RUN on enable=1.
REQ-022 In STOP, no new reads SHALL issue; buffered and in-flight words SHALL still be delivered.
REQ-023 FIFO going empty SHALL stall reads without leaving RUN.
REQ-024 word_count SHALL increment by 1 per transfer and wrap from all-ones to 0.

Reset
REQ-025 On reset low: state=IDLE, rd_en=0, m_valid=0, m_data=0, busy=0, word_count=0, buffer and in-flight flag cleared, immediately and asynchronously.
REQ-026 Reset asserted mid-operation SHALL discard buffered and in-flight words; a read accepted in the reset cycle is lost.
REQ-027 Reset release SHALL be synchronized internally; first rd_en no earlier than second rising edge after release.

Configuration
REQ-028 With FIFO_READER_CHECKSUM_EN defined, output port checksum (DATA_WIDTH) SHALL hold the running XOR of all transferred words, reset to 0.
REQ-029 Without FIFO_READER_CHECKSUM_EN, the checksum port and logic SHALL be absent.

Structure
REQ-030 Package fifo_reader_pkg SHALL hold the state enum (IDLE, RUN, STOP) and default DATA_WIDTH/CNT_WIDTH constants.
REQ-031 The 2-entry skid buffer SHALL be sub-module fifo_reader_skid; FSM, read issue and counter stay in fifo_reader.

Verification
REQ-032 Reset release, enable=1, FIFO holding 0..9, m_ready=1 -> m_data 0..9 on consecutive cycles, word_count=10.
REQ-033 FIFO holding 0..9, m_ready toggled 1/0 every cycle -> all ten words in order, m_data stable during stalls, no more than 2 buffered.
REQ-034 enable dropped after 3 reads issued -> reads stop, 3 words delivered, busy falls, state IDLE.
REQ-035 empty asserted mid-stream after word 4 -> rd_en=0, m_valid falls after word 4, resumes with word 5 when empty deasserts.
REQ-036 reset low while m_valid=1 -> m_valid, rd_en, word_count 0 same cycle; next run starts cleanly.
REQ-037 With FIFO_READER_CHECKSUM_EN, words 0x1,0x2,0x4 -> checksum=0x7.
